// File: rtl/fetch_pkg.sv
// Shared widths, constants and types for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned WORD_W           = 16;
    localparam logic [15:0] PC_STEP          = 16'd2;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
    localparam int unsigned MEM_WORDS        = 64;

    typedef enum logic [1:0] {
        OccEmpty,
        OccPartial,
        OccFull
    } occ_e;

    typedef struct packed {
        logic [WORD_W-1:0] ins;
        logic [WORD_W-1:0] pc;
    } qentry_t;

    // Instructions are halfword aligned; bit 0 of any target is dropped.
    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
        return {pc[WORD_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of {instruction, pc} pairs with synchronous flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    localparam int unsigned PTR_W = $clog2(QDEPTH),
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  qentry_t          i_entry,
    input  logic             i_pop,
    input  logic             i_flush,
    output qentry_t          o_head,
    output logic [CNT_W-1:0] o_count
);

    qentry_t          r_mem [QDEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            // Storage is left stale; count=0 hides it from the consumer.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_entry;
                r_tail        <= r_tail + 1'b1;
            end
            if (i_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, shares the memory port with the data stage
// (data has priority) and queues fetched words toward decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       QDEPTH   = 2,
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [WORD_W-1:0] a,
    output logic              we,
    output logic [WORD_W-1:0] wd,
    input  logic [WORD_W-1:0] rd,
    input  logic              dreq,
    input  logic              dwe,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dwd,
    output logic [WORD_W-1:0] drd,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] ins,
    output logic [WORD_W-1:0] ins_pc,
    output logic              ins_valid,
    input  logic              ins_ready
);

    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    logic [WORD_W-1:0] r_pc;
    logic [CNT_W-1:0]  w_count;
    occ_e              w_occ;
    logic              w_pop;
    logic              w_fetch;
    qentry_t           w_head;
    qentry_t           w_push_entry;

    always_comb begin
        w_occ = OccPartial;
        if (w_count == '0) begin
            w_occ = OccEmpty;
        end else if (w_count == CNT_W'(QDEPTH)) begin
            w_occ = OccFull;
        end
    end

    assign ins_valid = (w_occ != OccEmpty);
    assign w_pop     = ins_valid & ins_ready & ~redirect;
    // A full queue may still fetch when the head leaves in the same cycle.
    assign w_fetch   = ~redirect & ~dreq & ((w_occ != OccFull) | w_pop);

    always_comb begin
        a  = r_pc;
        we = 1'b0;
        wd = '0;
        if (dreq) begin
            a  = daddr;
            we = dwe;
            wd = dwd;
        end
    end

    assign drd = rd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= align_pc(redirect_pc);
        end else if (w_fetch) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    assign w_push_entry = '{ins: rd, pc: r_pc};

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_fetch),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign ins    = w_head.ins;
    assign ins_pc = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed table and corner sequences plus random traffic,
// all cross-checked against a queue-based reference model.
module tb_fetch_unit;

    localparam int unsigned QD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, wd, rd, daddr, dwd, drd, redirect_pc, ins, ins_pc;
    logic        we, dreq, dwe, redirect, ins_valid, ins_ready;

    logic [15:0] mem [64];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] q_ins [$];
    logic [15:0] q_pc  [$];
    logic [15:0] m_pc;
    bit          m_known = 1'b0;

    typedef struct {
        bit          rdy;
        logic [15:0] e_valid;
        logic [15:0] e_ins;
        logic [15:0] e_pc;
        logic [15:0] e_a;
    } vec_t;

    always #5 clk = ~clk;

    assign rd = mem[a[6:1]];
    always @(posedge clk) if (we) mem[a[6:1]] <= wd;

    fetch_unit #(
        .QDEPTH   (QD),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .we          (we),
        .wd          (wd),
        .rd          (rd),
        .dreq        (dreq),
        .dwe         (dwe),
        .daddr       (daddr),
        .dwd         (dwd),
        .drd         (drd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ins         (ins),
        .ins_pc      (ins_pc),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [15:0] ea;
        ea = dreq ? daddr : m_pc;
        check("m_a", a, ea);
        check("m_we", {15'b0, we}, {15'b0, dreq & dwe});
        check("m_wd", wd, dreq ? dwd : 16'h0000);
        check("m_drd", drd, mem[ea[6:1]]);
        check("m_valid", {15'b0, ins_valid}, {15'b0, q_ins.size() > 0});
        if (q_ins.size() > 0) begin
            check("m_ins", ins, q_ins[0]);
            check("m_ins_pc", ins_pc, q_pc[0]);
        end
    endtask

    task automatic set_in(input bit rst, input bit rdy, input bit dq, input bit dw,
                          input logic [15:0] da, input logic [15:0] dd,
                          input bit rdr, input logic [15:0] rp);
        @(negedge clk);
        rst_n       = rst;
        ins_ready   = rdy;
        dreq        = dq;
        dwe         = dw;
        daddr       = da;
        dwd         = dd;
        redirect    = rdr;
        redirect_pc = rp;
        #1;
        if (m_known) compare_model();
    endtask

    task automatic tick();
        bit          p, f;
        logic [15:0] r;
        p = (q_ins.size() > 0) && ins_ready && !redirect;
        f = !redirect && !dreq && ((q_ins.size() < QD) || p);
        r = mem[m_pc[6:1]];
        @(posedge clk);
        if (!rst_n) begin
            q_ins.delete();
            q_pc.delete();
            m_pc    = 16'h0000;
            m_known = 1'b1;
        end else if (m_known) begin
            if (redirect) begin
                q_ins.delete();
                q_pc.delete();
                m_pc = {redirect_pc[15:1], 1'b0};
            end else begin
                if (p) begin
                    void'(q_ins.pop_front());
                    void'(q_pc.pop_front());
                end
                if (f) begin
                    q_ins.push_back(r);
                    q_pc.push_back(m_pc);
                    m_pc = m_pc + 16'd2;
                end
            end
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
            tick();
        end
    endtask

    initial begin
        vec_t        vt [4];
        logic [15:0] exp2 [3];

        vt[0] = '{1'b1, 16'h0, 16'h0000, 16'h0000, 16'h0000};
        vt[1] = '{1'b1, 16'h1, 16'h0A3C, 16'h0000, 16'h0002};
        vt[2] = '{1'b1, 16'h1, 16'h0A4D, 16'h0002, 16'h0004};
        vt[3] = '{1'b1, 16'h1, 16'h2B7C, 16'h0004, 16'h0006};
        exp2[0] = 16'h0A3C;
        exp2[1] = 16'h0A4D;
        exp2[2] = 16'h2B7C;

        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0A3C;
        mem[1] = 16'h0A4D;
        mem[2] = 16'h2B7C;
        mem[3] = 16'h24D4;
        mem[9] = 16'hB6F8;
        rst_n = 0; ins_ready = 0; dreq = 0; dwe = 0; daddr = 0; dwd = 0;
        redirect = 0; redirect_pc = 0;

        // Streaming after reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, vt[i].rdy, 0, 0, 16'h0, 16'h0, 0, 16'h0);
            check("t1_valid", {15'b0, ins_valid}, vt[i].e_valid);
            check("t1_ins", ins, vt[i].e_ins);
            check("t1_ins_pc", ins_pc, vt[i].e_pc);
            check("t1_a", a, vt[i].e_a);
            tick();
        end

        // Back-pressure fills the queue, then drains in order
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
            if (i == 4) begin
                check("t2_held_a", a, 16'h0004);
                check("t2_valid", {15'b0, ins_valid}, 16'h1);
                check("t2_head", ins, 16'h0A3C);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0);
            check("t2_drain", ins, exp2[i]);
            tick();
        end

        // Store takes the port; pc must not advance
        set_in(1, 1, 1, 1, 16'h0010, 16'hBEEF, 0, 16'h0);
        check("t3_a", a, 16'h0010);
        check("t3_we", {15'b0, we}, 16'h1);
        check("t3_wd", wd, 16'hBEEF);
        tick();
        set_in(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        check("t3_pc_held", a, 16'h000A);
        tick();
        set_in(1, 0, 0, 0, 16'h0, 16'h0, 1, 16'h0010);
        tick();
        set_in(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        check("t3_flush_valid", {15'b0, ins_valid}, 16'h0);
        check("t3_redir_a", a, 16'h0010);
        tick();
        set_in(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        check("t3_beef", ins, 16'hBEEF);
        check("t3_beef_pc", ins_pc, 16'h0010);
        tick();

        // Redirect from a full queue with an odd target
        set_in(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        check("t4_full_held", a, 16'h0014);
        tick();
        set_in(1, 0, 0, 0, 16'h0, 16'h0, 1, 16'h0013);
        tick();
        set_in(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        check("t4_valid", {15'b0, ins_valid}, 16'h0);
        check("t4_a", a, 16'h0012);
        tick();
        set_in(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        check("t4_ins", ins, 16'hB6F8);
        check("t4_ins_pc", ins_pc, 16'h0012);
        tick();

        // Redirect + load + ready in one cycle
        set_in(1, 1, 1, 0, 16'h0006, 16'h0, 1, 16'h0000);
        check("t5_drd", drd, 16'h24D4);
        check("t5_a", a, 16'h0006);
        check("t5_we", {15'b0, we}, 16'h0);
        tick();
        set_in(1, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        check("t5_valid", {15'b0, ins_valid}, 16'h0);
        check("t5_a2", a, 16'h0000);
        tick();
        set_in(1, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        check("t5_ins", ins, 16'h0A3C);
        check("t5_ins_pc", ins_pc, 16'h0000);
        tick();

        // Reset overrides a full queue, redirect and store; then wrap at FFFE
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
            tick();
        end
        set_in(0, 1, 1, 1, 16'h0020, 16'h1234, 1, 16'h0040);
        check("t6_rst_a", a, 16'h0020);
        check("t6_rst_we", {15'b0, we}, 16'h1);
        tick();
        set_in(1, 1, 0, 0, 16'h0, 16'h0, 1, 16'hFFFE);
        check("t6_valid", {15'b0, ins_valid}, 16'h0);
        check("t6_a", a, 16'h0000);
        check("t6_ins", ins, 16'h0000);
        check("t6_ins_pc", ins_pc, 16'h0000);
        tick();
        set_in(1, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        check("t6_a_fffe", a, 16'hFFFE);
        tick();
        set_in(1, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        check("t6_ins_pc", ins_pc, 16'hFFFE);
        check("t6_wrap_a", a, 16'h0000);
        tick();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(63) != 0, $urandom_range(3) != 0, $urandom_range(3) == 0,
                   1'($urandom_range(1)), 16'($urandom_range(63)) << 1, 16'($urandom),
                   $urandom_range(7) == 0, 16'($urandom));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
